// File: rtl/demux_pkg.sv
// ----------------------------------------------------------------------------
// demux_pkg : shared sizing constants for the buffered 1x2 demultiplexer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package demux_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned DEFAULT_DEPTH = 2;
  localparam int unsigned COUNT_W       = 8;

  // Destination encoding of the Select bit.
  typedef enum logic {
    DEST_OUT_0 = 1'b0,
    DEST_OUT_1 = 1'b1
  } dest_e;

endpackage : demux_pkg

`default_nettype wire

// File: rtl/demux_out_fifo.sv
// ----------------------------------------------------------------------------
// demux_out_fifo : one output FIFO of the demux with a registered head word;
// delivery counter present only when DEMUX_COUNT_EN is defined.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module demux_out_fifo
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_full
`ifdef DEMUX_COUNT_EN
  ,
  output logic [COUNT_W-1:0] o_count
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;

  logic push_en;
  logic pop_en;
  logic empty;
  logic [PTR_W-1:0] rd_next;

  assign empty   = (count_q == '0);
  assign o_full  = (count_q == FULL_CNT);
  assign o_valid = !empty;
  assign o_data  = head_q;

  assign push_en = i_push && !o_full;
  assign pop_en  = i_ready && !empty;
  assign rd_next = rd_ptr_q + PTR_ONE;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;

    if (push_en) begin
      mem_d[wr_ptr_q] = i_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end

    if (pop_en) begin
      rd_ptr_d = rd_next;
    end

    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // The head register tracks the entry rd_ptr will point at after this edge;
    // a word written this edge into that slot must bypass the array.
    if (pop_en) begin
      if (push_en && (wr_ptr_q == rd_next)) begin
        head_d = i_data;
      end else begin
        head_d = mem_q[rd_next];
      end
    end else if (push_en && empty) begin
      head_d = i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // Storage carries no reset: stale entries are unreachable once count is 0.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef DEMUX_COUNT_EN
  logic [COUNT_W-1:0] deliv_q, deliv_d;

  always_comb begin
    deliv_d = deliv_q;
    if (pop_en) begin
      deliv_d = deliv_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deliv_q <= '0;
    end else begin
      deliv_q <= deliv_d;
    end
  end

  assign o_count = deliv_q;
`endif

endmodule : demux_out_fifo

`default_nettype wire

// File: rtl/four_bit_1x2_demux_buffered.sv
// ----------------------------------------------------------------------------
// four_bit_1x2_demux_buffered : steers each input word into one of two output
// FIFOs by Select. Optional delivery counters: DEMUX_COUNT_EN. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module four_bit_1x2_demux_buffered
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] In,
  input  logic             Select,
  input  logic             In_Valid,
  output logic             In_Ready,
  output logic [WIDTH-1:0] Out_0,
  output logic             Out_0_Valid,
  input  logic             Out_0_Ready,
  output logic [WIDTH-1:0] Out_1,
  output logic             Out_1_Valid,
  input  logic             Out_1_Ready
`ifdef DEMUX_COUNT_EN
  ,
  output logic [COUNT_W-1:0] Count_0,
  output logic [COUNT_W-1:0] Count_1
`endif
);

  logic full_0;
  logic full_1;
  logic push_0;
  logic push_1;
  logic accept;

  // Readiness depends only on the FIFO the current word is headed for.
  assign In_Ready = !Reset && ((Select == DEST_OUT_1) ? !full_1 : !full_0);
  assign accept   = In_Valid && In_Ready;
  assign push_0   = accept && (Select == DEST_OUT_0);
  assign push_1   = accept && (Select == DEST_OUT_1);

  demux_out_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_0 (
    .clk     (Clock),
    .rst     (Reset),
    .i_push  (push_0),
    .i_data  (In),
    .i_ready (Out_0_Ready),
    .o_data  (Out_0),
    .o_valid (Out_0_Valid),
    .o_full  (full_0)
`ifdef DEMUX_COUNT_EN
    ,
    .o_count (Count_0)
`endif
  );

  demux_out_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_1 (
    .clk     (Clock),
    .rst     (Reset),
    .i_push  (push_1),
    .i_data  (In),
    .i_ready (Out_1_Ready),
    .o_data  (Out_1),
    .o_valid (Out_1_Valid),
    .o_full  (full_1)
`ifdef DEMUX_COUNT_EN
    ,
    .o_count (Count_1)
`endif
  );

endmodule : four_bit_1x2_demux_buffered

`default_nettype wire

// File: doc/four_bit_1x2_demux_buffered.md
# four_bit_1x2_demux_buffered

Buffered 1-to-2 demultiplexer: accepts a WIDTH-bit word on a valid/ready input and steers it, by a per-word Select bit, into one of two independent output FIFOs, each drained by its own valid/ready port. It is the splitting counterpart of the lab's 2x1 mux datapath. It sits between a single producer and two consumers that stall independently, so one stalled consumer never corrupts or drops the other's traffic.

## Interface
- WIDTH, 4, data width of input and both outputs
- DEPTH, 2, entries per output FIFO; power of two, ≥2
- Clock  input  1  rising-edge clock, sole clock domain
- Reset  input  1  synchronous, active-high reset
- In  input  WIDTH  input data word
- Select  input  1  destination of the current word: 0 → Out_0, 1 → Out_1
- In_Valid  input  1  producer presents In/Select
- In_Ready  output  1  selected FIFO can accept this cycle
- Out_0 / Out_1  output  WIDTH  head word of FIFO 0 / FIFO 1
- Out_0_Valid / Out_1_Valid  output  1  FIFO 0 / FIFO 1 non-empty
- Out_0_Ready / Out_1_Ready  input  1  consumer 0 / consumer 1 takes head
- Count_0 / Count_1  output  8  words delivered per port (only with DEMUX_COUNT_EN)

## Operation
- Input transfer: In_Valid && In_Ready at a rising edge; word is pushed into FIFO[Select].
- In_Ready = !Reset && !full[Select]. It is combinational on Select; the other FIFO's state is irrelevant.
- Output transfer k: Out_k_Valid && Out_k_Ready; head popped, read pointer advances.
- Out_k_Valid = !empty[k]; Out_k is the registered head entry, stable while Valid && !Ready.
- Per FIFO: write pointer, read pointer (log2(DEPTH) bits, wrap DEPTH-1 → 0), occupancy count (log2(DEPTH)+1 bits). full = (count == DEPTH), empty = (count == 0).
- Simultaneous push and pop on same FIFO: count unchanged, both pointers advance.
- Push on full FIFO: not possible (In_Ready low), even if the same-cycle pop would free a slot; no pass-through.
- Pop on empty FIFO: ignored, no pointer movement.
- Select may change every cycle; ordering is preserved per destination only.
- Producer must hold In/Select/In_Valid stable until accepted; the block does not check this.

## Timing
- Reset (any cycle, including mid-transfer): all pointers and counts → 0; Out_0_Valid = Out_1_Valid = 0; Out_0 = Out_1 = 0; Count_0 = Count_1 = 0; In_Ready = 0 during reset and 1 in the first cycle after it. Contents in flight are discarded.
- Latency: word accepted at edge N appears with Out_k_Valid = 1 after edge N (1 cycle); no combinational In → Out path.
- Throughput: one word per cycle per FIFO when the consumer keeps Ready high.
- Status flags update on the same edge as the transfer that causes them.

## Configuration
- DEMUX_COUNT_EN defined: Count_k is an 8-bit register incremented on every output transfer of port k, wrapping 255 → 0; cleared by Reset.
- Undefined: Count_0/Count_1 ports and registers are absent. Datapath behaviour is identical in both builds.

## Structure
- Package demux_pkg: default WIDTH and DEPTH constants, and the COUNT_W = 8 constant.
- Sub-module demux_out_fifo (push/pop/data/full/empty, optional counter): instantiated twice; the top level holds only the Select steering and the In_Ready mux.

## Test plan
- Reset: hold Reset 2 cycles with In_Valid = 1 → no valid outputs, In_Ready = 0, Count_k = 0; In_Ready = 1 the first cycle after release.
- Steering: send 4'h3 (Select = 0), 4'hA (Select = 1), Out_k_Ready = 1 → Out_0 = 3 and Out_1 = A, each valid exactly one cycle after acceptance.
- Independent stall: Out_1_Ready = 0; push 3 words to port 1 → first 2 accepted; third held with In_Ready = 0; words to port 0 still flow every cycle.
- Full plus pop: FIFO 1 full, Out_1_Ready = 1 with a Select = 1 word pending → In_Ready stays 0 that cycle, word accepted the next cycle; order 1,2,3 preserved.
- Wrap: 300 words to port 0 under continuous Ready → data in order across pointer wraps; Count_0 = 44 (DEMUX_COUNT_EN).
- Mid-stream reset with both FIFOs holding 2 words → both valids 0 the next cycle; post-reset word 4'h5 delivered alone.
